// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled on the shared tick enable, pushing good bytes into the RX FIFO.
// Define UART_RX_MAJORITY_EN to decide every bit by a 2-of-3 vote around mid-bit instead of a single sample.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 CLK288MHZ,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 uart_rxd_out,
    input  logic                 fifoFull,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 writeEn,
    output logic                 frameErr,
    output logic                 overrunErr,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

`ifdef UART_RX_MAJORITY_EN
    // Vote completes one tick after mid-bit; entering DATA at 1 keeps every later decision at a wrapped 0.
    localparam logic [CW-1:0] START_DEC  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] BIT_DEC    = '0;
    localparam logic [CW-1:0] DATA_ENTRY = CW'(1);
`else
    localparam logic [CW-1:0] START_DEC  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_DEC    = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] DATA_ENTRY = '0;
`endif
    localparam logic [BW-1:0] LAST_IDX = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [BW-1:0]          bit_idx, idx_nxt;
    logic [DATA_BITS-1:0]   shreg, shreg_nxt;
    logic [DATA_BITS-1:0]   data_nxt;
    logic                   wr_nxt, ferr_nxt, oerr_nxt;
    logic                   rx_p0, rxS;
    logic                   bit_val;

    // Stage p0 -> rxS: two-flop synchroniser for the asynchronous line
    always_ff @(posedge CLK288MHZ or posedge reset) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rxS   <= 1'b1;
        end else begin
            rx_p0 <= uart_rxd_out;
            rxS   <= rx_p0;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Last two tick samples; with the current rxS they form the mid-1, mid, mid+1 window
    always_ff @(posedge CLK288MHZ or posedge reset) begin
        if (reset) begin
            hist <= 2'b11;
        end else if (tick) begin
            hist <= {hist[0], rxS};
        end
    end

    always_comb begin
        bit_val = maj3(hist[1], hist[0], rxS);
    end
`else
    always_comb begin
        bit_val = rxS;
    end
`endif

    always_ff @(posedge CLK288MHZ or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            dataOut    <= '0;
            writeEn    <= 1'b0;
            frameErr   <= 1'b0;
            overrunErr <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= idx_nxt;
            shreg      <= shreg_nxt;
            dataOut    <= data_nxt;
            writeEn    <= wr_nxt;
            frameErr   <= ferr_nxt;
            overrunErr <= oerr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = bit_idx;
        shreg_nxt = shreg;
        data_nxt  = dataOut;
        wr_nxt    = 1'b0;
        ferr_nxt  = 1'b0;
        oerr_nxt  = 1'b0;

        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (!rxS) begin
                        state_nxt = S_START;
                        cnt_nxt   = '0;
                    end
                end

                S_START: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == START_DEC) begin
                        if (!bit_val) begin
                            state_nxt = S_DATA;
                            cnt_nxt   = DATA_ENTRY;
                            idx_nxt   = '0;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end

                // Counter wraps naturally, so STOP starts with the same phase as the data bits
                S_DATA: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == BIT_DEC) begin
                        shreg_nxt = {bit_val, shreg[DATA_BITS-1:1]};
                        idx_nxt   = bit_idx + 1'b1;
                        if (bit_idx == LAST_IDX) begin
                            state_nxt = S_STOP;
                        end
                    end
                end

                // Leave at mid stop bit so a start edge right after it is not missed
                S_STOP: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == BIT_DEC) begin
                        if (bit_val) begin
                            state_nxt = S_IDLE;
                            if (fifoFull) begin
                                oerr_nxt = 1'b1;
                            end else begin
                                wr_nxt   = 1'b1;
                                data_nxt = shreg;
                            end
                        end else begin
                            ferr_nxt  = 1'b1;
                            state_nxt = S_BREAK;
                        end
                    end
                end

                S_BREAK: begin
                    if (rxS) begin
                        state_nxt = S_IDLE;
                    end
                end

                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule
